// File: rtl/sigma_buffer_pp_if.sv
// Writer/reader bus of the rotating sigma coefficient buffer.
// Optional parity_err exists only when SIGMA_BUFFER_PARITY_EN is defined.
interface sigma_buffer_pp_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] wraddress;
    logic              wren;
    logic              wr_commit;
    logic              wr_ready;
    logic [ADDR_W-1:0] rdaddress;
    logic              rden;
    logic              rd_release;
    logic              rd_ready;
    logic [DATA_W-1:0] q;
    logic              q_valid;
    logic [2:0]        occupancy;
`ifdef SIGMA_BUFFER_PARITY_EN
    logic              parity_err;
`endif

    modport master (
        output data, wraddress, wren, wr_commit, rdaddress, rden, rd_release,
        input  wr_ready, rd_ready, q, q_valid, occupancy
`ifdef SIGMA_BUFFER_PARITY_EN
        , input parity_err
`endif
    );

    modport slave (
        input  data, wraddress, wren, wr_commit, rdaddress, rden, rd_release,
        output wr_ready, rd_ready, q, q_valid, occupancy
`ifdef SIGMA_BUFFER_PARITY_EN
        , output parity_err
`endif
    );
endinterface

// File: rtl/sigma_buffer_pp.sv
// Purpose: multi-bank sigma coefficient buffer between BM (writer) and Chien/Forney (reader); optional word parity via SIGMA_BUFFER_PARITY_EN.
// Latency: read data registered, q/q_valid exactly one cycle after an honoured rden.
// Backpressure: wren/wr_commit ignored while all banks are full; rden/rd_release ignored while none are full.
module sigma_buffer_pp #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int NUM_BANKS = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    sigma_buffer_pp_if.slave bus
);
    localparam int BANK_W = (NUM_BANKS > 2) ? 2 : 1;
`ifdef SIGMA_BUFFER_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif
    localparam int              DEPTH = NUM_BANKS << ADDR_W;
    localparam logic [2:0]      NB    = 3'(NUM_BANKS);
    localparam logic [BANK_W-1:0] LAST = BANK_W'(NUM_BANKS - 1);

    logic [WORD_W-1:0] mem [DEPTH];

    logic [BANK_W-1:0] wr_ptr;
    logic [BANK_W-1:0] rd_ptr;
    logic [2:0]        occ;
    logic              wr_ok;
    logic              rd_ok;
    logic              wr_fire;
    logic              cm_fire;
    logic              rd_fire;
    logic              rl_fire;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;
    logic [DATA_W-1:0] q_r;
    logic              q_valid_r;

    assign wr_ok   = (occ < NB);
    assign rd_ok   = (occ != 3'd0);
    assign wr_fire = bus.wren & wr_ok;
    assign cm_fire = bus.wr_commit & wr_ok;
    assign rd_fire = bus.rden & rd_ok;
    assign rl_fire = bus.rd_release & rd_ok;

`ifdef SIGMA_BUFFER_PARITY_EN
    assign wr_word = {^bus.data, bus.data};
`else
    assign wr_word = bus.data;
`endif

    // Writer only ever owns free banks and reader only full ones, so no bypass is needed.
    always_ff @(posedge clock) begin
        if (wr_fire) begin
            mem[{wr_ptr, bus.wraddress}] <= wr_word;
        end
    end

    assign rd_word = mem[{rd_ptr, bus.rdaddress}];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= 3'd0;
            q_r       <= '0;
            q_valid_r <= 1'b0;
        end else begin
            q_valid_r <= rd_fire;
            if (rd_fire) begin
                q_r <= rd_word[DATA_W-1:0];
            end
            if (cm_fire) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (rl_fire) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({cm_fire, rl_fire})
                2'b10:   occ <= occ + 3'd1;
                2'b01:   occ <= occ - 3'd1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef SIGMA_BUFFER_PARITY_EN
    logic parity_err_r;

    // Stored bit is the even parity of the data, so a clean word XORs to zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            parity_err_r <= 1'b0;
        end else begin
            parity_err_r <= rd_fire & (^rd_word);
        end
    end

    assign bus.parity_err = parity_err_r;
`endif

    assign bus.wr_ready  = wr_ok;
    assign bus.rd_ready  = rd_ok;
    assign bus.q         = q_r;
    assign bus.q_valid   = q_valid_r;
    assign bus.occupancy = occ;
endmodule

// File: doc/sigma_buffer_pp.md
Name: sigma_buffer_pp

Overview:
- Parametrised multi-bank successor to the single-bank sigma coefficient RAM in the RS decoder.
- Holds error-locator (sigma) coefficient sets between the Berlekamp-Massey stage (writer) and the Chien/Forney stage (reader).
- Banks rotate per codeword, so BM can fill bank N+1 while Chien reads bank N.
- Bank ownership is tracked with a commit/release handshake and occupancy counter; reads are registered.

Parameters:
- DATA_W, 8, coefficient width in bits (GF(2^m) symbol).
- ADDR_W, 8, word address width per bank; depth per bank = 2^ADDR_W.
- NUM_BANKS, 2, number of rotating banks; legal values 2..4.

Ports:
- clock  in  1  sole clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- data  in  DATA_W  write coefficient.
- wraddress  in  ADDR_W  write address within the current write bank.
- wren  in  1  write strobe; honoured only when wr_ready=1.
- wr_commit  in  1  marks the current write bank full and advances the write bank pointer.
- wr_ready  out  1  a free bank is owned by the writer.
- rdaddress  in  ADDR_W  read address within the current read bank.
- rden  in  1  read strobe; honoured only when rd_ready=1.
- rd_release  in  1  frees the current read bank and advances the read bank pointer.
- rd_ready  out  1  at least one full bank is available to the reader.
- q  out  DATA_W  registered read data.
- q_valid  out  1  q holds data from a read honoured on the previous cycle.
- occupancy  out  3  number of full banks, 0..NUM_BANKS.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - wr_ptr=0, rd_ptr=0, occupancy=0.
  - wr_ready=1, rd_ready=0, q=0, q_valid=0.
  - RAM contents are not reset.
- Pointers are mod-NUM_BANKS counters.
- Physical RAM address is {bank, address}, inferred as simple dual-port RAM, NUM_BANKS*2^ADDR_W words.
- Status flags: wr_ready = (occupancy < NUM_BANKS); rd_ready = (occupancy != 0). Both are combinational from registered state.
- Write: if wren && wr_ready, the word is written at (wr_ptr, wraddress) at the clock edge. If wr_ready=0, wren is ignored and RAM is unchanged.
- Commit: if wr_commit && wr_ready, wr_ptr increments (wrapping NUM_BANKS-1 to 0) and occupancy increments.
  - wren and wr_commit in the same cycle: the write lands in the old bank, then the pointer advances.
  - wr_commit while wr_ready=0 is ignored.
- Read: if rden && rd_ready, the next cycle has q=RAM[rd_ptr, rdaddress] and q_valid=1. Latency is exactly 1 cycle.
  - When the read is not honoured, q_valid=0 next cycle and q holds its last value.
- Release: if rd_release && rd_ready, rd_ptr increments (wrapping) and occupancy decrements.
  - rden and rd_release in the same cycle: the read uses the old bank; q is still delivered next cycle.
  - rd_release while rd_ready=0 is ignored.
- Commit and release honoured in the same cycle: both pointers advance and occupancy is unchanged.
  - When occupancy=NUM_BANKS, commit is not honoured, so only release applies.
  - When occupancy=0, release is not honoured, so only commit applies.
- Read/write bank collision cannot occur: the writer owns only free banks and the reader only full banks. No bypass logic.
- Reset mid-operation: all banks become free, any in-flight q_valid is dropped, and the partial codeword is discarded.

Optional Feature:
- Macro SIGMA_BUFFER_PARITY_EN.
- Defined:
  - Each RAM word stores an extra even-parity bit computed from data at write time.
  - An extra output port, parity_err (1 bit), is registered alongside q.
  - parity_err=1 when a honoured read returns a word whose recomputed parity mismatches the stored bit.
  - parity_err resets to 0 and is 0 whenever q_valid=0.
- Not defined: no parity storage and no parity_err port; RAM width is exactly DATA_W.

Test Plan:
- Reset then idle: reset_n=0 for 3 cycles -> wr_ready=1, rd_ready=0, occupancy=0, q=0, q_valid=0.
- Basic ping-pong, NUM_BANKS=2:
  - Stimulus: write 0x11..0x18 at addr 0..7, commit; write 0xA1..0xA8, commit.
  - Required: occupancy=2, wr_ready=0.
  - Read addr 0..7 -> q=0x11..0x18, each one cycle after rden. Release, then read -> 0xA1..0xA8.
- Full backpressure: with occupancy=2, wren=1 data=0xFF addr=0 plus wr_commit -> RAM unchanged (later read of bank0 addr0 still 0x11), occupancy stays 2.
- Simultaneous commit+release at occupancy=1 -> occupancy stays 1, wr_ptr and rd_ptr both advance, wrapping 1->0.
- Empty read: rden=1 with occupancy=0 -> q_valid=0 next cycle, q unchanged. Assert reset_n=0 mid-read -> q_valid drops to 0 immediately (async).
- Parity (SIGMA_BUFFER_PARITY_EN): write 0x5A, force-flip the stored parity bit via a hierarchical deposit, read -> q=0x5A, q_valid=1, parity_err=1. An unflipped word reads with parity_err=0.
